// File: rtl/gmii_rx_axis_packer_pkg.sv
// Shared types, byte constants and CRC helpers for the GMII receive packer.
// The CRC helpers are used only when GMII_PACK_FCS_CHECK_EN is defined.
package gmii_rx_axis_packer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        DROP
    } rx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
    localparam int          HDR_ID_LANE   = 0;
    localparam int          HDR_SEQ_LANE  = 1;

    function automatic logic [31:0] reverse32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // LSB-first CRC-32 step; the register holds the bit-reversed form of the
    // textbook CRC, so callers compare reverse32(crc) against CRC_RESIDUE.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        logic [31:0] poly_r;
        poly_r = reverse32(CRC_POLY);
        c = crc ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ poly_r) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/gmii_rx_axis_packer_if.sv
// AXI-Stream bundle carrying packed frame beats out of the GMII receive packer.
interface gmii_rx_axis_packer_if #(
    parameter int DATA_W = 64
);
    logic                  tvalid;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;
    logic                  tuser;
    logic                  tready;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/gmii_rx_axis_packer_fifo.sv
// First-word-fall-through synchronous FIFO; reports its free entry count so the
// writer can keep one slot back for a frame terminator.
module gmii_rx_axis_packer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         valid,
    output logic [$clog2(DEPTH):0]       free
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    // A write into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_rd   = rd_en && (count != '0);
    assign do_wr   = wr_en && ((count != CW'(DEPTH)) || do_rd);
    assign valid   = (count != '0);
    assign free    = CW'(DEPTH) - count;
    assign rd_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/gmii_rx_axis_packer.sv
// GMII receive to AXI-Stream packer: strips preamble/SFD, emits a node header beat,
// packs bytes into DATA_W beats through a FIFO. Optional FCS check: GMII_PACK_FCS_CHECK_EN.
module gmii_rx_axis_packer
    import gmii_rx_axis_packer_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             node_id,
    input  logic [3:0]             eth_type,
    input  logic                   gmii_rx_dv,
    input  logic [7:0]             gmii_rxd,
    input  logic                   gmii_rx_er,
    gmii_rx_axis_packer_if.master  m_axis,
    output logic [CNT_W-1:0]       frame_cnt,
    output logic [CNT_W-1:0]       drop_cnt
);
    localparam int KEEP_W  = DATA_W / 8;
    localparam int LANE_W  = $clog2(KEEP_W);
    localparam int PC_W    = LANE_W + 1;
    localparam int FREE_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = DATA_W + KEEP_W + 2;

    rx_state_t          state, state_next;
    logic [DATA_W-1:0]  pack_data, pack_data_next;
    logic [PC_W-1:0]    pack_cnt, pack_cnt_next;
    logic               err_flag, err_next;
    logic [7:0]         seq, seq_next;
    logic               frame_inc, drop_inc;
    logic               push, push_last, push_user;
    logic [DATA_W-1:0]  push_data;
    logic [KEEP_W-1:0]  push_keep, keep_partial;
    logic [FREE_W-1:0]  fifo_free;
    logic               fifo_valid;
    logic [ENTRY_W-1:0] fifo_out;
    logic               fcs_bad;
    logic               pack_full;
    logic               room;

`ifdef GMII_PACK_FCS_CHECK_EN
    logic [31:0] crc;

    // CRC restarts whenever the FSM is outside DATA, so it covers exactly the frame bytes.
    always_ff @(posedge clk) begin
        if (rst || state != DATA) crc <= CRC_INIT;
        else if (gmii_rx_dv)      crc <= crc32_byte(crc, gmii_rxd);
    end

    assign fcs_bad = (reverse32(crc) != CRC_RESIDUE);
`else
    assign fcs_bad = 1'b0;
`endif

    assign pack_full = (pack_cnt == PC_W'(KEEP_W));
    assign room      = (fifo_free >= FREE_W'(2));

    always_comb begin
        keep_partial = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            keep_partial[i] = (PC_W'(i) < pack_cnt);
        end
    end

    // A full pack word is held back until the next byte or dv fall decides its tlast.
    always_comb begin
        state_next     = state;
        pack_data_next = pack_data;
        pack_cnt_next  = pack_cnt;
        err_next       = err_flag;
        seq_next       = seq;
        frame_inc      = 1'b0;
        drop_inc       = 1'b0;
        push           = 1'b0;
        push_data      = '0;
        push_keep      = '0;
        push_last      = 1'b0;
        push_user      = 1'b0;
        case (state)
            IDLE, PRE: begin
                if (!gmii_rx_dv) begin
                    state_next = IDLE;
                end else if (gmii_rxd == PREAMBLE_BYTE) begin
                    state_next = PRE;
                end else if (gmii_rxd == SFD_BYTE) begin
                    if (room) begin
                        push = 1'b1;
                        push_data[HDR_ID_LANE*8 +: 8]  = {node_id, eth_type};
                        push_data[HDR_SEQ_LANE*8 +: 8] = seq;
                        push_keep      = '1;
                        seq_next       = seq + 8'd1;
                        pack_data_next = '0;
                        pack_cnt_next  = '0;
                        err_next       = 1'b0;
                        state_next     = DATA;
                    end else begin
                        drop_inc   = 1'b1;
                        state_next = DROP;
                    end
                end else begin
                    state_next = DROP;
                end
            end
            DATA: begin
                if (gmii_rx_dv && pack_full && !room) begin
                    push       = 1'b1;
                    push_keep  = KEEP_W'(1);
                    push_last  = 1'b1;
                    push_user  = 1'b1;
                    drop_inc   = 1'b1;
                    state_next = DROP;
                end else if (gmii_rx_dv && pack_full) begin
                    push           = 1'b1;
                    push_data      = pack_data;
                    push_keep      = '1;
                    pack_data_next = DATA_W'(gmii_rxd);
                    pack_cnt_next  = PC_W'(1);
                    err_next       = err_flag | gmii_rx_er;
                end else if (gmii_rx_dv) begin
                    pack_data_next[pack_cnt[LANE_W-1:0]*8 +: 8] = gmii_rxd;
                    pack_cnt_next  = pack_cnt + PC_W'(1);
                    err_next       = err_flag | gmii_rx_er;
                end else if (pack_cnt == '0) begin
                    push       = 1'b1;
                    push_keep  = KEEP_W'(1);
                    push_last  = 1'b1;
                    push_user  = 1'b1;
                    drop_inc   = 1'b1;
                    state_next = IDLE;
                end else begin
                    push       = 1'b1;
                    push_data  = pack_data;
                    push_keep  = keep_partial;
                    push_last  = 1'b1;
                    push_user  = err_flag | fcs_bad;
                    frame_inc  = 1'b1;
                    state_next = IDLE;
                end
            end
            DROP: begin
                if (!gmii_rx_dv) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pack_data <= '0;
            pack_cnt  <= '0;
            err_flag  <= 1'b0;
            seq       <= '0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_next;
            pack_data <= pack_data_next;
            pack_cnt  <= pack_cnt_next;
            err_flag  <= err_next;
            seq       <= seq_next;
            if (frame_inc) frame_cnt <= frame_cnt + CNT_W'(1);
            if (drop_inc)  drop_cnt  <= drop_cnt + CNT_W'(1);
        end
    end

    gmii_rx_axis_packer_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data ({push_user, push_last, push_keep, push_data}),
        .rd_en   (m_axis.tready),
        .rd_data (fifo_out),
        .valid   (fifo_valid),
        .free    (fifo_free)
    );

    assign m_axis.tvalid = fifo_valid;
    assign m_axis.tdata  = fifo_out[DATA_W-1:0];
    assign m_axis.tkeep  = fifo_out[DATA_W +: KEEP_W];
    assign m_axis.tlast  = fifo_out[DATA_W+KEEP_W];
    assign m_axis.tuser  = fifo_out[DATA_W+KEEP_W+1];

endmodule
